// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
// The signed variant is enabled by defining MULDIV_SIGNED_EN.
package muldiv_pkg;

    localparam int DEF_WIDTH = 32;

    function automatic int last_step(input int w);
        return w - 1;
    endfunction

    localparam int STEP_LAST = last_step(DEF_WIDTH);

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } state_e;

    // Per-operation control captured at START and consumed in FIX.
    typedef struct packed {
        logic is_div;
        logic neg_res;
        logic neg_rem;
    } op_ctl_t;

endpackage

// File: rtl/muldiv_abs.sv
// Combinational two's-complement conditional negate (abs when neg = sign bit).
// Only built with MULDIV_SIGNED_EN.
`ifdef MULDIV_SIGNED_EN
module muldiv_abs #(
    parameter int W = 32
) (
    input  logic [W-1:0] val,
    input  logic         neg,
    output logic [W-1:0] res
);

    assign res = neg ? (~val + W'(1)) : val;

endmodule
`endif

// File: rtl/muldiv_unit.sv
// Iterative 32-step shift-add multiply / restoring divide with HI/LO result registers.
// Define MULDIV_SIGNED_EN to honour OP[0] (signed MULT/DIV); otherwise all ops are unsigned.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [1:0]       OP,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic             DIV_ZERO,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(last_step(WIDTH));

    state_e             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opb;
    op_ctl_t            ctl;

    logic               in_signed;
    logic               div_zero_req;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH-1:0]   mul_addend;
    logic [WIDTH:0]     mul_sum, div_trial, div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    assign div_zero_req = START & OP[1] & (B == '0);

`ifdef MULDIV_SIGNED_EN
    assign in_signed = OP[0];

    muldiv_abs #(.W(WIDTH)) u_abs_a (.val(A), .neg(in_signed & A[WIDTH-1]), .res(a_mag));
    muldiv_abs #(.W(WIDTH)) u_abs_b (.val(B), .neg(in_signed & B[WIDTH-1]), .res(b_mag));

    muldiv_abs #(.W(2*WIDTH)) u_neg_prod (.val(acc), .neg(ctl.neg_res), .res(prod_fix));
    muldiv_abs #(.W(WIDTH)) u_neg_quo (.val(acc[WIDTH-1:0]), .neg(ctl.neg_res), .res(quo_fix));
    muldiv_abs #(.W(WIDTH)) u_neg_rem (.val(acc[2*WIDTH-1:WIDTH]), .neg(ctl.neg_rem), .res(rem_fix));
`else
    logic cfg_unused;

    assign in_signed  = 1'b0;
    assign a_mag      = A;
    assign b_mag      = B;
    assign prod_fix   = acc;
    assign quo_fix    = acc[WIDTH-1:0];
    assign rem_fix    = acc[2*WIDTH-1:WIDTH];
    assign cfg_unused = ^{OP[0], ctl.neg_res, ctl.neg_rem};
`endif

    // Multiply: multiplier sits in acc low half and shifts out as the product shifts in.
    assign mul_addend = acc[0] ? opb : '0;
    assign mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};

    // Divide: acc = {remainder, dividend/quotient}; remainder < divisor keeps the MSB a clean borrow.
    assign div_trial  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_diff   = div_trial - {1'b0, opb};
    assign div_ge     = ~div_diff[WIDTH];

    assign acc_step = ctl.is_div
                    ? {(div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0]), acc[WIDTH-2:0], div_ge}
                    : {mul_sum, acc[WIDTH-1:1]};

    assign fix_hi = ctl.is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
    assign fix_lo = ctl.is_div ? quo_fix : prod_fix[WIDTH-1:0];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (START) state_nxt = div_zero_req ? S_DONE : S_CALC;
            S_CALC: if (cnt == LAST) state_nxt = S_FIX;
            S_FIX:  state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt      <= '0;
            acc      <= '0;
            opb      <= '0;
            ctl      <= '0;
            HI       <= '0;
            LO       <= '0;
            DIV_ZERO <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
        end else begin
            BUSY <= (state_nxt != S_IDLE);
            DONE <= (state_nxt == S_DONE);
            case (state)
                S_IDLE: if (START) begin
                    cnt         <= '0;
                    acc         <= {{WIDTH{1'b0}}, a_mag};
                    opb         <= b_mag;
                    ctl.is_div  <= OP[1];
                    ctl.neg_res <= in_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                    ctl.neg_rem <= in_signed & A[WIDTH-1];
                    DIV_ZERO    <= div_zero_req;
                    // Divide by zero bypasses CALC/FIX, so the result is loaded here.
                    if (div_zero_req) begin
                        HI <= A;
                        LO <= '1;
                    end
                end
                S_CALC: begin
                    acc <= acc_step;
                    cnt <= cnt + 1'b1;
                end
                S_FIX: begin
                    HI <= fix_hi;
                    LO <= fix_lo;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed scoreboard bench for muldiv_unit; expectations follow MULDIV_SIGNED_EN.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = DEF_WIDTH;

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic         START = 1'b0;
    logic [1:0]   OP = 2'b00;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         BUSY, DONE, DIV_ZERO;
    logic [W-1:0] HI, LO;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string        tag;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           lat;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] prev_hi = '0;
    logic [W-1:0] prev_lo = '0;
    logic [63:0]  p;

    always #5 CLK = ~CLK;

    muldiv_unit #(.WIDTH(W)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .OP(OP), .A(A), .B(B),
        .BUSY(BUSY), .DONE(DONE), .DIV_ZERO(DIV_ZERO), .HI(HI), .LO(LO)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive START for one cycle; returns at the negedge after the accepting edge.
    task automatic issue(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] hi, input logic [W-1:0] lo,
                         input logic dz, input int lat);
        exp_t e;
        e.tag = tag; e.hi = hi; e.lo = lo; e.dz = dz; e.lat = lat;
        @(negedge CLK);
        OP = op; A = a; B = b; START = 1'b1;
        sb.push_back(e);
        @(negedge CLK);
        START = 1'b0;
        A = $urandom;
        B = $urandom;
    endtask

    task automatic finish_op(input int pulse_at);
        exp_t e;
        int   k;
        e = sb.pop_front();
        k = 0;
        chk({e.tag, "/busy"}, 64'(BUSY), 64'(1));
        while (!DONE && k < 60) begin
            if (k == 5) begin
                chk({e.tag, "/hi_hold"}, 64'(HI), 64'(prev_hi));
                chk({e.tag, "/lo_hold"}, 64'(LO), 64'(prev_lo));
            end
            if (k == pulse_at) begin
                START = 1'b1;
                OP = 2'($urandom);
                A = $urandom;
                B = $urandom;
            end
            if (k == pulse_at + 1) START = 1'b0;
            @(negedge CLK);
            k++;
        end
        START = 1'b0;
        chk({e.tag, "/lat"}, 64'(k), 64'(e.lat));
        chk({e.tag, "/hi"}, 64'(HI), 64'(e.hi));
        chk({e.tag, "/lo"}, 64'(LO), 64'(e.lo));
        chk({e.tag, "/dz"}, 64'(DIV_ZERO), 64'(e.dz));
        @(negedge CLK);
        chk({e.tag, "/done_pulse"}, 64'(DONE), 64'(0));
        chk({e.tag, "/idle"}, 64'(BUSY), 64'(0));
        chk({e.tag, "/dz_sticky"}, 64'(DIV_ZERO), 64'(e.dz));
        prev_hi = e.hi;
        prev_lo = e.lo;
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst/busy", 64'(BUSY), 64'(0));
        chk("rst/done", 64'(DONE), 64'(0));
        chk("rst/dz", 64'(DIV_ZERO), 64'(0));
        chk("rst/hi", 64'(HI), 64'(0));
        chk("rst/lo", 64'(LO), 64'(0));
        RST_N = 1'b1;

        issue("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33);
        finish_op(-1);

`ifdef MULDIV_SIGNED_EN
        issue("mult_neg", OP_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33);
        finish_op(-1);
        issue("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33);
        finish_op(-1);
        issue("div_7_m2", OP_DIV, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 33);
        finish_op(-1);
        issue("div_m7_m2", OP_DIV, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0, 33);
        finish_op(-1);
        issue("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33);
        finish_op(-1);
`else
        issue("mult_neg", OP_MULT, 32'hFFFFFFFD, 32'd7, 32'h00000006, 32'hFFFFFFEB, 1'b0, 33);
        finish_op(-1);
        issue("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'h00000001, 32'h7FFFFFFC, 1'b0, 33);
        finish_op(-1);
        issue("div_7_m2", OP_DIV, 32'd7, 32'hFFFFFFFE, 32'h00000007, 32'h00000000, 1'b0, 33);
        finish_op(-1);
        issue("div_m7_m2", OP_DIV, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFF9, 32'h00000000, 1'b0, 33);
        finish_op(-1);
        issue("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0, 33);
        finish_op(-1);
`endif

        issue("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'h00000002, 32'h0000000E, 1'b0, 33);
        finish_op(-1);

        p = 64'h12345678 * 64'h9ABCDEF0;
        issue("multu_mix", OP_MULTU, 32'h12345678, 32'h9ABCDEF0, p[63:32], p[31:0], 1'b0, 33);
        finish_op(-1);

        issue("divu_5_0", OP_DIVU, 32'd5, 32'd0, 32'h00000005, 32'hFFFFFFFF, 1'b1, 0);
        finish_op(-1);
        issue("divu_4_2", OP_DIVU, 32'd4, 32'd2, 32'h00000000, 32'h00000002, 1'b0, 33);
        finish_op(-1);
        issue("div_m5_0", OP_DIV, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, 0);
        finish_op(-1);

        // A START mid-CALC must not disturb the operation in flight.
        p = 64'h0000FFFF * 64'h00010001;
        issue("start_busy", OP_MULTU, 32'h0000FFFF, 32'h00010001, p[63:32], p[31:0], 1'b0, 33);
        finish_op(10);

        issue("abort", OP_MULTU, 32'h00001234, 32'h00000010, 32'h0, 32'h0, 1'b0, 33);
        repeat (10) @(negedge CLK);
        RST_N = 1'b0;
        #1;
        chk("abort/busy", 64'(BUSY), 64'(0));
        chk("abort/done", 64'(DONE), 64'(0));
        chk("abort/dz", 64'(DIV_ZERO), 64'(0));
        chk("abort/hi", 64'(HI), 64'(0));
        chk("abort/lo", 64'(LO), 64'(0));
        void'(sb.pop_front());
        prev_hi = '0;
        prev_lo = '0;
        @(negedge CLK);
        RST_N = 1'b1;

        issue("multu_3_4", OP_MULTU, 32'd3, 32'd4, 32'h00000000, 32'h0000000C, 1'b0, 33);
        finish_op(-1);

        chk("sb_empty", 64'(sb.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
